// File: rtl/multiplicador_booth.sv
// Sequential signed radix-2 Booth multiplier: one add/sub plus arithmetic shift per clock.
// An asynchronous, level-acting start loads the operands, and Fin flags a valid product.
module multiplicador_booth #(
  parameter int NUM_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_BITS-1:0]   multiplicador,
  input  logic [NUM_BITS-1:0]   multiplicando,
  input  logic                  start,
  output logic [2*NUM_BITS-1:0] resultado,
  output logic                  Fin
);

  localparam int CNT_W = $clog2(NUM_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  // Accumulator and multiplicand carry one guard bit, so A-M cannot overflow when M is the most negative value.
  logic [NUM_BITS:0]   acc;
  logic [NUM_BITS:0]   mcand;
  logic [NUM_BITS:0]   acc_sum;
  logic [NUM_BITS-1:0] mplier;
  logic                q_prev;
  logic [CNT_W-1:0]    cnt;

  always_comb begin
    acc_sum = acc;
    unique case ({mplier[0], q_prev})
      2'b01:   acc_sum = acc + mcand;
      2'b10:   acc_sum = acc - mcand;
      default: acc_sum = acc;
    endcase
  end

  // start acts as an asynchronous load, so it shares the sensitivity list with the reset.
  always_ff @(posedge clk or negedge rst_n or posedge start) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      q_prev <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {multiplicando[NUM_BITS-1], multiplicando};
      mplier <= multiplicador;
      q_prev <= 1'b0;
      cnt    <= CNT_W'(NUM_BITS);
    end else if (cnt != '0) begin
      acc    <= {acc_sum[NUM_BITS], acc_sum[NUM_BITS:1]};
      mplier <= {acc_sum[0], mplier[NUM_BITS-1:1]};
      q_prev <= mplier[0];
      cnt    <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n or posedge start) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (start) begin
      state <= S_RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  state_nx = S_IDLE;
      S_RUN:   if (cnt == CNT_W'(1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    Fin = (state == S_DONE);
  end

  assign resultado = {acc[NUM_BITS-1:0], mplier};

endmodule

// File: tb/tb_multiplicador_booth.sv
// Self-checking bench for multiplicador_booth (NUM_BITS=3): directed cases, full operand sweep,
// latency, restart, asynchronous reset, with a queue of expected products.
`timescale 1ns/1ps
module tb_multiplicador_booth;

  localparam int N = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [N-1:0]     multiplicador = '0;
  logic [N-1:0]     multiplicando = '0;
  logic [2*N-1:0]   resultado;
  logic             Fin;

  int n_cmp = 0;
  int n_mis = 0;
  int fin_rises = 0;
  int exp_rises = 0;
  logic [2*N-1:0] sb[$];

  multiplicador_booth #(.NUM_BITS(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .multiplicador (multiplicador),
    .multiplicando (multiplicando),
    .start         (start),
    .resultado     (resultado),
    .Fin           (Fin)
  );

  always #5 clk = ~clk;

  always @(posedge Fin) fin_rises++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // 1 ns start pulse placed between clock edges; Fin must be low while start is high.
  task automatic pulse(input int mq, input int mm);
    @(negedge clk);
    #2;
    multiplicador = N'(mq);
    multiplicando = N'(mm);
    start = 1'b1;
    #0.5;
    chk("fin_during_start", {31'b0, Fin}, 32'd0);
    #0.5;
    start = 1'b0;
  endtask

  task automatic wait_fin(output int lat, input bit scramble);
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (Fin === 1'b1) lat = k;
      if (scramble) begin
        multiplicador = N'($urandom);
        multiplicando = N'($urandom);
      end
    end
  endtask

  task automatic finish_op(input string tag, input bit scramble);
    int lat;
    logic [2*N-1:0] e;
    wait_fin(lat, scramble);
    chk({tag, "_latency"}, lat, 32'd3);
    e = sb.pop_front();
    chk({tag, "_result"}, {26'b0, resultado}, {26'b0, e});
    chk({tag, "_fin_rises"}, fin_rises, exp_rises);
  endtask

  task automatic op(input string tag, input int mq, input int mm, input bit scramble);
    pulse(mq, mm);
    sb.push_back((2*N)'(mq * mm));
    exp_rises++;
    finish_op(tag, scramble);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset_fin", {31'b0, Fin}, 32'd0);
    chk("reset_result", {26'b0, resultado}, 32'd0);
    #10 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_fin", {31'b0, Fin}, 32'd0);

    op("m4xm4", -4, -4, 1'b0);
    chk("m4xm4_value", {26'b0, resultado}, 32'b010000);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold_fin", {31'b0, Fin}, 32'd1);
    chk("done_hold_result", {26'b0, resultado}, 32'b010000);

    op("m4x3", 3, -4, 1'b1);
    chk("m4x3_value", {26'b0, resultado}, 32'b110100);
    op("3xm1", -1, 3, 1'b0);
    chk("3xm1_value", {26'b0, resultado}, 32'b111101);
    op("0xm4", -4, 0, 1'b0);
    chk("0xm4_value", {26'b0, resultado}, 32'b000000);

    for (int i = -4; i < 4; i++) begin
      for (int j = -4; j < 4; j++) begin
        #20;
        op("sweep", i, j, 1'b0);
      end
    end

    // Restart: the first operation is aborted and must not raise Fin.
    pulse(3, 2);
    @(posedge clk);
    #1;
    pulse(3, -2);
    sb.push_back((2*N)'(-6));
    exp_rises++;
    finish_op("restart", 1'b0);
    chk("restart_value", {26'b0, resultado}, 32'b111010);

    pulse(3, 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset_fin", {31'b0, Fin}, 32'd0);
    chk("midrun_reset_result", {26'b0, resultado}, 32'd0);
    #5 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("after_reset_no_fin", {31'b0, Fin}, 32'd0);
    chk("after_reset_rises", fin_rises, exp_rises);

    op("post_reset", 2, -3, 1'b0);
    chk("queue_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
